// File: rtl/serial_link_floo_multi_chan_bridge.sv
// Multiplexes NumChan NoC flit channels onto one AXIS link and back.
// Ports: clk_i/rst_ni; chan_*_i/_o flit channels; axis_out_*/axis_in_*
// links; err_cnt_o counts inbound beats whose header names no channel.

// Default AXIS bundle, sized for NumChan=3 / FlitWidth=64
// (tdata = 64-bit flit + 2-bit header). Custom types must carry
// the same field names (t.data, t.strb, ..., tvalid / tready).
typedef struct packed {
  logic [65:0] data;
  logic [8:0]  strb;
  logic [8:0]  keep;
  logic        last;
  logic [7:0]  id;
  logic [7:0]  dest;
  logic [7:0]  user;
} floo_axis_t;

typedef struct packed {
  floo_axis_t t;
  logic       tvalid;
} floo_axis_req_t;

typedef struct packed {
  logic tready;
} floo_axis_rsp_t;

module serial_link_floo_multi_chan_bridge #(
  parameter int unsigned NumChan   = 3,
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned MaxBurst  = 4,
  parameter int unsigned FifoDepth = 2,
  parameter logic [NumChan-1:0][63:0] ChanStrb = '1,
  parameter bit IgnoreAssert = 1'b0,
  parameter type axis_req_t = floo_axis_req_t,
  parameter type axis_rsp_t = floo_axis_rsp_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NumChan-1:0] chan_valid_i,
  output logic [NumChan-1:0] chan_ready_o,
  input  logic [NumChan-1:0][FlitWidth-1:0] chan_data_i,
  output logic [NumChan-1:0] chan_valid_o,
  input  logic [NumChan-1:0] chan_ready_i,
  output logic [NumChan-1:0][FlitWidth-1:0] chan_data_o,
  output axis_req_t axis_out_req_o,
  input  axis_rsp_t axis_out_rsp_i,
  input  axis_req_t axis_in_req_i,
  output axis_rsp_t axis_in_rsp_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned HdrW =
    (NumChan > 1) ? $clog2(NumChan) : 1;
  localparam int unsigned DataW = FlitWidth + HdrW;
  localparam int unsigned StrbW = (DataW + 7) / 8;
  localparam int unsigned PtrW =
    (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  typedef logic [HdrW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;

  localparam idx_t LastIdx = idx_t'(NumChan - 1);
  localparam ptr_t LastPtr = ptr_t'(FifoDepth - 1);
  localparam logic [7:0] BurstMax = 8'(MaxBurst);
  localparam logic [HdrW:0] ChanLim = (HdrW+1)'(NumChan);
  localparam logic [CntW-1:0] Full = CntW'(FifoDepth);

  typedef enum logic {IDLE, LOCK} state_e;

  function automatic idx_t nxt_idx(input idx_t i);
    return (i == LastIdx) ? '0 : i + idx_t'(1);
  endfunction

  function automatic ptr_t nxt_ptr(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  state_e state_q, state_d;
  idx_t sel_q, sel_d, ptr_q, ptr_d, sel;
  logic [7:0] cnt_q, cnt_d;
  logic any_vld, fwd_vld;
  logic [DataW-1:0] fwd_data;

  logic [DataW-1:0] mem_q [FifoDepth];
  ptr_t wr_q, rd_q;
  logic [CntW-1:0] fcnt_q;
  logic out_vld, push, pop, fifo_rdy;
  logic [DataW-1:0] head;

  logic [15:0] err_cnt_q;
  idx_t in_hdr;
  logic in_legal;

  // Round-robin pick: first valid channel at or after ptr_q.
  always_comb begin
    int unsigned c;
    sel = ptr_q;
    any_vld = 1'b0;
    c = 0;
    for (int unsigned k = 0; k < NumChan; k++) begin
      c = 32'(ptr_q) + k;
      if (c >= NumChan) c = c - NumChan;
      if (!any_vld && chan_valid_i[c]) begin
        any_vld = 1'b1;
        sel = idx_t'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    fwd_vld = 1'b0;
    fwd_data = '0;
    chan_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          fwd_vld = 1'b1;
          fwd_data = {chan_data_i[sel], sel};
          chan_ready_o[sel] = fifo_rdy;
          if (fifo_rdy && MaxBurst == 1) begin
            ptr_d = nxt_idx(sel);
          end else begin
            state_d = LOCK;
            sel_d = sel;
            cnt_d = fifo_rdy ? 8'd1 : 8'd0;
          end
        end
      end
      LOCK: begin
        // A dropped valid ends the burst with a bubble cycle.
        if (!chan_valid_i[sel_q]) begin
          state_d = IDLE;
          ptr_d = nxt_idx(sel_q);
        end else begin
          fwd_vld = 1'b1;
          fwd_data = {chan_data_i[sel_q], sel_q};
          chan_ready_o[sel_q] = fifo_rdy;
          if (fifo_rdy) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == BurstMax) begin
              state_d = IDLE;
              ptr_d = nxt_idx(sel_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Outbound FIFO; a full FIFO still accepts when the head leaves.
  // Held in reset, nothing is accepted so no beat is silently lost.
  assign out_vld = (fcnt_q != '0);
  assign pop = out_vld && axis_out_rsp_i.tready;
  assign fifo_rdy = rst_ni && ((fcnt_q != Full) || pop);
  assign push = fwd_vld && fifo_rdy;
  assign head = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wr_q <= nxt_ptr(wr_q);
      if (pop) rd_q <= nxt_ptr(rd_q);
      unique case ({push, pop})
        2'b10: fcnt_q <= fcnt_q + CntW'(1);
        2'b01: fcnt_q <= fcnt_q - CntW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= fwd_data;
  end

  always_comb begin
    axis_out_req_o = '0;
    axis_out_req_o.tvalid = out_vld;
    if (out_vld) begin
      axis_out_req_o.t.data = head;
      for (int unsigned k = 0; k < NumChan; k++) begin
        if (head[HdrW-1:0] == idx_t'(k)) begin
          axis_out_req_o.t.strb = ChanStrb[k][StrbW-1:0];
        end
      end
    end
  end

  // Inbound demux is purely combinational.
  assign in_hdr = axis_in_req_i.t.data[HdrW-1:0];
  assign in_legal = ({1'b0, in_hdr} < ChanLim);

  always_comb begin
    chan_valid_o = '0;
    axis_in_rsp_o = '0;
    axis_in_rsp_o.tready = 1'b1;
    for (int unsigned k = 0; k < NumChan; k++) begin
      chan_data_o[k] =
        axis_in_req_i.t.data[HdrW +: FlitWidth];
      if (in_legal && in_hdr == idx_t'(k)) begin
        chan_valid_o[k] = axis_in_req_i.tvalid;
        axis_in_rsp_o.tready = chan_ready_i[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (axis_in_req_i.tvalid && !in_legal &&
                 err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;

  logic unused_in;
  assign unused_in = ^{axis_in_req_i.t.strb,
                       axis_in_req_i.t.keep,
                       axis_in_req_i.t.last,
                       axis_in_req_i.t.id,
                       axis_in_req_i.t.dest,
                       axis_in_req_i.t.user};

  if (!IgnoreAssert) begin : g_asserts
    a_chan_range: assert property (@(posedge clk_i)
      NumChan >= 2 && NumChan <= 16);
    a_burst_range: assert property (@(posedge clk_i)
      MaxBurst >= 1 && MaxBurst <= 255);
    a_out_stable: assert property (@(posedge clk_i)
      disable iff (!rst_ni)
      axis_out_req_o.tvalid && !axis_out_rsp_i.tready
      |=> $stable(axis_out_req_o.t.data) &&
          $stable(axis_out_req_o.t.strb));
    for (genvar g = 0; g < NumChan; g++) begin : g_hold
      a_vld_hold: assert property (@(posedge clk_i)
        disable iff (!rst_ni)
        chan_valid_i[g] && !chan_ready_o[g]
        |=> chan_valid_i[g]);
    end
  end

endmodule

// File: tb/tb_serial_link_floo_multi_chan_bridge.sv
// Scoreboard bench for the multi-channel flit/AXIS bridge.
// Directed bursts, backpressure, inbound demux and mid-burst reset.
module tb_serial_link_floo_multi_chan_bridge;

  localparam int NC = 3;
  localparam int FW = 64;

  typedef struct packed {
    logic [NC-1:0] vld;
    logic [NC-1:0][FW-1:0] data;
    logic rdy;
  } in_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] chan_valid, chan_ready, cvo, cri;
  logic [NC-1:0][FW-1:0] chan_data, cdo;
  floo_axis_req_t out_req, in_req;
  floo_axis_rsp_t out_rsp, in_rsp;
  logic [15:0] err_cnt;
  logic sink_ready;

  int errors = 0;
  int checks = 0;
  int src_left [NC];
  int src_cnt [NC];
  int exp_n [NC];
  logic [8:0] strb_tab [NC] = '{9'h1FF, 9'h0F0, 9'h00F};
  floo_axis_req_t exp_q [$];
  in_exp_t in_q [$];

  always #5 clk = ~clk;

  assign out_rsp.tready = sink_ready;

  serial_link_floo_multi_chan_bridge #(
    .NumChan(NC),
    .FlitWidth(FW),
    .MaxBurst(4),
    .FifoDepth(2),
    .ChanStrb({64'h00F, 64'h0F0, 64'h1FF}),
    .IgnoreAssert(1'b0),
    .axis_req_t(floo_axis_req_t),
    .axis_rsp_t(floo_axis_rsp_t)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .chan_valid_i(chan_valid),
    .chan_ready_o(chan_ready),
    .chan_data_i(chan_data),
    .chan_valid_o(cvo),
    .chan_ready_i(cri),
    .chan_data_o(cdo),
    .axis_out_req_o(out_req),
    .axis_out_rsp_i(out_rsp),
    .axis_in_req_i(in_req),
    .axis_in_rsp_o(in_rsp),
    .err_cnt_o(err_cnt)
  );

  function automatic logic [63:0] dat(int c, int n);
    return 64'hA000_0000_C0DE_0000 |
           (64'(c) << 56) | 64'(n);
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NC; i++)
      if (src_left[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_out(int c);
    floo_axis_req_t e;
    e = '0;
    e.tvalid = 1'b1;
    e.t.data = {dat(c, exp_n[c]), 2'(c)};
    e.t.strb = strb_tab[c];
    exp_n[c]++;
    exp_q.push_back(e);
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((busy() || exp_q.size() != 0 ||
            out_req.tvalid) && n < 300) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s drain timeout left=%0d",
               nm, exp_q.size());
    end
  endtask

  task automatic in_beat(int hdr, logic [63:0] f,
                         logic [NC-1:0] rdy,
                         logic [NC-1:0] evld, logic erdy);
    in_exp_t e;
    in_req = '0;
    in_req.tvalid = 1'b1;
    in_req.t.data = {f, 2'(hdr)};
    cri = rdy;
    e.vld = evld;
    e.data = {NC{f}};
    e.rdy = erdy;
    in_q.push_back(e);
    cyc(1);
    in_req = '0;
    cri = '0;
  endtask

  // Channel sources: hold valid/data until handshake.
  initial begin
    logic [NC-1:0] hs;
    chan_valid = '0;
    chan_data = '0;
    forever begin
      @(negedge clk);
      hs = rst_n ? (chan_valid & chan_ready) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
        if (hs[i]) begin
          src_left[i]--;
          src_cnt[i]++;
        end
        chan_valid[i] = (src_left[i] != 0);
        chan_data[i] = dat(i, src_cnt[i]);
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents output.
  initial begin
    floo_axis_req_t e;
    in_exp_t ie;
    forever begin
      @(negedge clk);
      if (rst_n && out_req.tvalid && out_rsp.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got=%h", out_req);
        end else begin
          e = exp_q.pop_front();
          if (out_req !== e) begin
            errors++;
            $display("FAIL out_beat got=%h exp=%h",
                     out_req, e);
          end
        end
      end
      if (in_req.tvalid) begin
        checks++;
        if (in_q.size() == 0) begin
          errors++;
          $display("FAIL in_unexpected vld=%b", cvo);
        end else begin
          ie = in_q.pop_front();
          if (cvo !== ie.vld || cdo !== ie.data ||
              in_rsp.tready !== ie.rdy) begin
            errors++;
            $display("FAIL in_beat got=%b/%h/%b exp=%b/%h/%b",
                     cvo, cdo, in_rsp.tready,
                     ie.vld, ie.data, ie.rdy);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] hd;
    int n;
    for (int i = 0; i < NC; i++) begin
      src_left[i] = 0;
      src_cnt[i] = 0;
      exp_n[i] = 0;
    end
    sink_ready = 1'b1;
    in_req = '0;
    cri = '0;
    cyc(3);
    chk("rst_tvalid", 128'(out_req.tvalid), 128'd0);
    chk("rst_ready", 128'(chan_ready), 128'd0);
    chk("rst_err", 128'(err_cnt), 128'd0);
    chk("rst_cvo", 128'(cvo), 128'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_ready", 128'(chan_ready), 128'd0);

    // All valid: 0x4, 1x4, 2x4, then channel 0 again.
    for (int c = 0; c < NC; c++)
      repeat (4) push_out(c);
    push_out(0);
    src_left[0] = 5;
    src_left[1] = 4;
    src_left[2] = 4;
    drain("rr_burst");

    // Short burst on channel 1 ends early.
    push_out(1);
    push_out(1);
    src_left[1] = 2;
    drain("short_burst");
    // Pointer now at 2: channel 2 idle wraps to 0.
    push_out(0);
    push_out(1);
    src_left[0] = 1;
    src_left[1] = 1;
    drain("wrap_to_0");
    push_out(2);
    push_out(0);
    src_left[2] = 1;
    src_left[0] = 1;
    drain("next_is_2");

    // Backpressure: two beats buffered, head held.
    sink_ready = 1'b0;
    hd = {dat(0, exp_n[0]), 2'd0};
    repeat (4) push_out(0);
    src_left[0] = 4;
    cyc(2);
    chk("stall_head0", 128'(out_req.t.data), 128'(hd));
    cyc(8);
    chk("stall_taken", 128'(src_left[0]), 128'd2);
    chk("stall_ready", 128'(chan_ready), 128'd0);
    chk("stall_head1", 128'(out_req.t.data), 128'(hd));
    chk("stall_tvalid", 128'(out_req.tvalid), 128'd1);
    sink_ready = 1'b1;
    drain("stall_release");

    // Inbound demux and illegal header drop.
    in_beat(2, 64'h1111_2222_3333_4444,
            3'b100, 3'b100, 1'b1);
    in_beat(3, 64'h5555_6666_7777_8888,
            3'b000, 3'b000, 1'b1);
    chk("err_one", 128'(err_cnt), 128'd1);
    in_beat(1, 64'h9999_AAAA_BBBB_CCCC,
            3'b000, 3'b010, 1'b0);
    in_beat(0, 64'hDDDD_EEEE_FFFF_0000,
            3'b001, 3'b001, 1'b1);
    chk("err_hold", 128'(err_cnt), 128'd1);

    // Reset while channel 2 presents the 3rd beat of its burst.
    sink_ready = 1'b0;
    src_left[2] = 5;
    src_left[0] = 2;
    n = 0;
    while (src_left[2] != 3 && n < 50) begin
      cyc(1);
      n++;
    end
    chk("pre_rst_wait", 128'(n < 50), 128'd1);
    cyc(1);
    chk("pre_rst_ready", 128'(chan_ready), 128'd0);
    chk("pre_rst_tvalid", 128'(out_req.tvalid), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", 128'(out_req.tvalid), 128'd0);
    chk("rst_mid_ready", 128'(chan_ready), 128'd0);
    push_out(0);
    push_out(0);
    exp_n[2] += 2;
    repeat (3) push_out(2);
    cyc(2);
    rst_n = 1'b1;
    sink_ready = 1'b1;
    drain("post_rst");

    cyc(3);
    chk("out_q_empty", 128'(exp_q.size()), 128'd0);
    chk("in_q_empty", 128'(in_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
